imem_boot_loader: RTL

//  Upstream loader for the single-cycle core's instruction memory. Receives a byte

---
 rtl/imem_boot_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream, writes
// little-endian words into instruction memory and releases core reset once verified.
module imem_boot_loader #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned TIMEOUT     = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wd,
  output logic        core_rst,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_loaded,
  output logic [2:0]  o_dbg_state
);

  localparam logic [2:0] S_LEN0 = 3'd0;
  localparam logic [2:0] S_LEN1 = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  // Byte transfer handshake: a byte moves on any posedge where in_valid && in_ready.
  // in_ready depends only on state, never on in_valid.
  logic [2:0]  r_state;
  logic [7:0]  r_len_lo;
  logic [15:0] r_len;
  logic [7:0]  r_xor;
  logic [1:0]  r_bcnt;
  logic [23:0] r_asm;
  logic [31:0] r_wd;
  logic        r_we;
  logic [15:0] r_words_loaded;
  logic [31:0] r_tcnt;

  logic        w_accept;
  logic        w_counting;
  logic        w_timeout;
  logic [15:0] w_len;
  logic [31:0] w_tnext;

  assign in_ready     = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                        (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_accept     = in_valid && in_ready;
  assign w_len        = {in_data, r_len_lo};
  assign w_counting   = (r_state == S_LEN1) || (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_tnext      = r_tcnt + 32'd1;
  // An accepted byte in the expiring cycle takes priority over the timeout.
  assign w_timeout    = (TIMEOUT != 0) && w_counting && !w_accept && (w_tnext == TIMEOUT);

  assign im_we        = r_we;
  assign im_addr      = {14'd0, r_words_loaded, 2'b00};
  assign im_wd        = r_wd;
  assign core_rst     = (r_state != S_DONE);
  assign load_done    = (r_state == S_DONE);
  assign load_err     = (r_state == S_ERR);
  assign words_loaded = r_words_loaded;
  assign o_dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_LEN0;
      r_len_lo       <= 8'd0;
      r_len          <= 16'd0;
      r_xor          <= 8'd0;
      r_bcnt         <= 2'd0;
      r_asm          <= 24'd0;
      r_wd           <= 32'd0;
      r_we           <= 1'b0;
      r_words_loaded <= 16'd0;
      r_tcnt         <= 32'd0;
    end else begin
      r_we <= 1'b0;
      if (r_we) r_words_loaded <= r_words_loaded + 16'd1;
      if (w_accept) r_xor <= r_xor ^ in_data;
      if (w_accept || !w_counting) r_tcnt <= 32'd0;
      else                         r_tcnt <= w_tnext;

      case (r_state)
        S_LEN0: begin
          if (w_accept) begin
            r_len_lo <= in_data;
            r_state  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (w_accept) begin
            r_len <= w_len;
            if ({16'd0, w_len} > DEPTH_WORDS) r_state <= S_ERR;
            else if (w_len == 16'd0)          r_state <= S_CSUM;
            else                              r_state <= S_DATA;
          end else if (w_timeout) begin
            r_state <= S_ERR;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_bcnt <= r_bcnt + 2'd1;
            case (r_bcnt)
              2'd0: r_asm[7:0]   <= in_data;
              2'd1: r_asm[15:8]  <= in_data;
              2'd2: r_asm[23:16] <= in_data;
              default: begin
                // Previous word's pulse has always retired by now, so
                // r_words_loaded is the index of the word just completed.
                r_wd <= {in_data, r_asm};
                r_we <= 1'b1;
                if (r_words_loaded == 16'(r_len - 16'd1)) r_state <= S_CSUM;
              end
            endcase
          end else if (w_timeout) begin
            r_state <= S_ERR;
          end
        end
        S_CSUM: begin
          if (w_accept)       r_state <= (in_data == r_xor) ? S_DONE : S_ERR;
          else if (w_timeout) r_state <= S_ERR;
        end
        S_DONE, S_ERR: begin
          if (start) begin
            r_state        <= S_LEN0;
            r_words_loaded <= 16'd0;
            r_xor          <= 8'd0;
            r_bcnt         <= 2'd0;
            r_tcnt         <= 32'd0;
          end
        end
        default: r_state <= S_LEN0;
      endcase
    end
  end

endmodule
